// File: rtl/mul_share_arb_if.sv
// mul_share_arb_if: requester, multiplier and response signals shared by mul_share_arb and its users.
interface mul_share_arb_if #(
    parameter int DW   = 12,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_a;
    logic [NREQ*DW-1:0] req_b;
    logic [DW-1:0]      mul_a;
    logic [DW-1:0]      mul_b;
    logic [DW-1:0]      mul_p;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data;
    logic               busy;
    modport master (
        output req_valid, req_a, req_b, mul_p,
        input  req_ready, mul_a, mul_b, rsp_valid, rsp_data, busy
    );
    modport slave (
        input  req_valid, req_a, req_b, mul_p,
        output req_ready, mul_a, mul_b, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/mul_share_arb.sv
// mul_share_arb: round-robin sharing of one pipelined modular_mul among NREQ requesters.
// Define MULARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module mul_share_arb #(
    parameter int DW      = 12,
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 3
) (
    input logic           clk,
    input logic           rst,
    mul_share_arb_if.slave bus
);
    localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] rsp_q;
    logic [IW-1:0]   gid;
    logic [IW-1:0]   base;
    logic            xfer;
    logic [DW-1:0]   a_q;
    logic [DW-1:0]   b_q;
    logic [MUL_LAT-1:0] tv;
    logic [IW-1:0]   tid [MUL_LAT];
    int              idx;
`ifdef MULARB_FIXED_PRIO_EN
    assign base = '0;
`else
    logic [IW-1:0] ptr;
    assign base = ptr;
    always_ff @(posedge clk or negedge rst)
        if (!rst) ptr <= '0;
        else if (xfer) ptr <= (gid == IW'(NREQ - 1)) ? '0 : gid + 1'b1;
`endif
    always_comb begin
        gnt  = '0;
        gid  = '0;
        xfer = 1'b0;
        idx  = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(base) + k) % NREQ;
            if (!xfer && bus.req_valid[idx]) begin
                xfer     = 1'b1;
                gid      = IW'(idx);
                gnt[idx] = 1'b1;
            end
        end
    end
    // the final response flop lines the tag up with P_out, MUL_LAT cycles after mul_a/mul_b
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            a_q   <= '0;
            b_q   <= '0;
            tv    <= '0;
            rsp_q <= '0;
            for (int s = 0; s < MUL_LAT; s++) tid[s] <= '0;
        end else begin
            a_q   <= xfer ? bus.req_a[int'(gid)*DW +: DW] : '0;
            b_q   <= xfer ? bus.req_b[int'(gid)*DW +: DW] : '0;
            tv[0] <= xfer;
            tid[0] <= gid;
            for (int s = 1; s < MUL_LAT; s++) begin
                tv[s]  <= tv[s-1];
                tid[s] <= tid[s-1];
            end
            rsp_q <= tv[MUL_LAT-1] ? NREQ'(1) << tid[MUL_LAT-1] : '0;
        end
    assign bus.req_ready = gnt;
    assign bus.mul_a     = a_q;
    assign bus.mul_b     = b_q;
    assign bus.rsp_valid = rsp_q;
    assign bus.rsp_data  = bus.mul_p;
    assign bus.busy      = |tv;
endmodule
